// File: rtl/fractal_sync_nbr_ctrl_if.sv
// Tile-side bus bundle of the neighbor sync controller: the request/response
// handshake with the tile plus the sync/wake wires to the neighbor nodes.
// The slave modport is the controller's view; master is the tile/neighbor side.
interface fractal_sync_nbr_ctrl_if #(
  parameter int unsigned N_DIR = 4,
  parameter int unsigned ID_W  = 2
);
  localparam int unsigned DIR_W = (N_DIR > 1) ? $clog2(N_DIR) : 1;

  // Tile request channel
  logic                    req_valid_i;
  logic                    req_ready_o;
  logic [DIR_W-1:0]        req_dir_i;
  logic [ID_W-1:0]         req_id_i;

  // Tile response channel
  logic                    rsp_valid_o;
  logic                    rsp_ready_i;
  logic [DIR_W-1:0]        rsp_dir_o;
  logic [ID_W-1:0]         rsp_id_o;
  logic                    rsp_error_o;

  // Neighbor node side
  logic [N_DIR-1:0]        nbr_sync_o;
  logic [ID_W-1:0]         nbr_id_o;
  logic [N_DIR-1:0]        nbr_wake_i;
  logic [N_DIR*ID_W-1:0]   nbr_id_i;

  modport slave (
    input  req_valid_i, req_dir_i, req_id_i,
    output req_ready_o,
    output rsp_valid_o, rsp_dir_o, rsp_id_o, rsp_error_o,
    input  rsp_ready_i,
    output nbr_sync_o, nbr_id_o,
    input  nbr_wake_i, nbr_id_i
  );

  modport master (
    output req_valid_i, req_dir_i, req_id_i,
    input  req_ready_o,
    input  rsp_valid_o, rsp_dir_o, rsp_id_o, rsp_error_o,
    output rsp_ready_i,
    input  nbr_sync_o, nbr_id_o,
    output nbr_wake_i, nbr_id_i
  );
endinterface

// File: rtl/fractal_sync_nbr_ctrl.sv
// Neighbor synchronization sequencer for one tile. Requests are buffered in a
// small FIFO and issued one at a time: a single-cycle sync pulse to the chosen
// neighbor node, a wait for that node's wake (bounded by an optional timeout),
// then a response to the tile carrying the wake id or an error.
module fractal_sync_nbr_ctrl #(
  parameter int unsigned N_DIR      = 4,
  parameter int unsigned ID_W       = 2,
  parameter int unsigned FIFO_DEPTH = 2,
  parameter int unsigned TIMEOUT    = 1024
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  fractal_sync_nbr_ctrl_if.slave       bus,
  output logic                         busy_o
);

  localparam int unsigned DIR_W   = (N_DIR > 1) ? $clog2(N_DIR) : 1;
  localparam int unsigned PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned FCNT_W  = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned CNT_W   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int unsigned DIR_NUM = 2 ** DIR_W;

  localparam logic [CNT_W-1:0]  CNT_LIMIT = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;
  localparam logic [PTR_W-1:0]  PTR_LAST  = PTR_W'(FIFO_DEPTH - 1);
  localparam logic [FCNT_W-1:0] FIFO_FULL = FCNT_W'(FIFO_DEPTH);

  // Table of encodable directions that map to a real neighbor node; keeps the
  // range check free of width-dependent constant comparisons.
  function automatic logic [DIR_NUM-1:0] gen_dir_ok();
    logic [DIR_NUM-1:0] m;
    m = '0;
    for (int i = 0; i < int'(DIR_NUM); i++) m[i] = (i < int'(N_DIR));
    return m;
  endfunction

  localparam logic [DIR_NUM-1:0] DIR_OK = gen_dir_ok();

  typedef struct packed {
    logic [DIR_W-1:0] dir;
    logic [ID_W-1:0]  id;
  } req_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RSP   = 2'd3
  } state_e;

  // ---------------------------------------------------------------------------
  // Request FIFO
  // ---------------------------------------------------------------------------
  req_t              fifo_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [FCNT_W-1:0] count_q, count_d;
  logic              fifo_empty;
  logic              fifo_full;
  logic              push;
  logic              pop;
  req_t              head;

  state_e            state_q, state_d;

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == FIFO_FULL);
  assign head       = fifo_q[rd_ptr_q];

  // The FSM consumes the head whenever it sits in IDLE with work pending,
  // which frees a slot in the same cycle, so a full FIFO can still accept.
  assign pop             = (state_q == ST_IDLE) && !fifo_empty;
  assign bus.req_ready_o = !fifo_full || pop;
  assign push            = bus.req_valid_i && bus.req_ready_o;

  // Pointer and occupancy next-state; pointers wrap at FIFO_DEPTH.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PTR_W'(1);
    unique case ({push, pop})
      2'b10:   count_d = count_q + FCNT_W'(1);
      2'b01:   count_d = count_q - FCNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // FIFO pointer/occupancy registers; reset flushes the buffer.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    // NOTE: sequential state is always written with non-blocking assignments so
    // every register samples the pre-edge value of its inputs.
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // FIFO storage write.
  always_ff @(posedge clk_i) begin
    // NOTE: the storage array is deliberately not reset; the empty count alone
    // guarantees no stale entry is ever read, and unreset RAM maps cleanly.
    if (push) fifo_q[wr_ptr_q] <= '{dir: bus.req_dir_i, id: bus.req_id_i};
  end

  // ---------------------------------------------------------------------------
  // Sync sequencer
  // ---------------------------------------------------------------------------
  logic [DIR_W-1:0] dir_q, dir_d;
  logic [ID_W-1:0]  id_q, id_d;
  logic [ID_W-1:0]  rsp_id_q, rsp_id_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ID_W-1:0]  wake_id;
  logic             wake_hit;

  // Only the wake line and id slice of the selected direction matter.
  assign wake_hit = bus.nbr_wake_i[dir_q];
  assign wake_id  = bus.nbr_id_i[dir_q*ID_W +: ID_W];

  // Next-state and datapath for the IDLE -> ISSUE -> WAIT -> RSP sequence.
  always_comb begin
    // NOTE: every combinationally assigned signal gets a default first, so no
    // path through the case can leave it unassigned and infer a latch.
    state_d  = state_q;
    dir_d    = dir_q;
    id_d     = id_q;
    rsp_id_d = rsp_id_q;
    err_d    = err_q;
    cnt_d    = cnt_q;

    unique case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          dir_d    = head.dir;
          id_d     = head.id;
          rsp_id_d = head.id;
          if (DIR_OK[head.dir]) begin
            err_d   = 1'b0;
            state_d = ST_ISSUE;
          end else begin
            err_d   = 1'b1;
            state_d = ST_RSP;
          end
        end
      end

      ST_ISSUE: begin
        cnt_d   = '0;
        state_d = ST_WAIT;
      end

      ST_WAIT: begin
        // Saturating counter: it must never wrap back into the timeout match.
        if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
        // A wake in the same cycle as the timeout limit takes priority.
        if (wake_hit) begin
          rsp_id_d = wake_id;
          err_d    = (wake_id != id_q);
          state_d  = ST_RSP;
        end else if ((TIMEOUT != 0) && (cnt_q == CNT_LIMIT)) begin
          rsp_id_d = id_q;
          err_d    = 1'b1;
          state_d  = ST_RSP;
        end
      end

      ST_RSP: begin
        if (bus.rsp_ready_i) state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // Sequencer registers; reset aborts any in-flight sync without a response.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= ST_IDLE;
      dir_q    <= '0;
      id_q     <= '0;
      rsp_id_q <= '0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      dir_q    <= dir_d;
      id_q     <= id_d;
      rsp_id_q <= rsp_id_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
    end
  end

  // Output decode: the sync pulse exists only in ISSUE and response fields
  // only in RSP, so all outputs read as zero outside those states.
  always_comb begin
    bus.nbr_sync_o  = '0;
    bus.nbr_id_o    = '0;
    bus.rsp_valid_o = 1'b0;
    bus.rsp_dir_o   = '0;
    bus.rsp_id_o    = '0;
    bus.rsp_error_o = 1'b0;
    if (state_q == ST_ISSUE) begin
      bus.nbr_sync_o[dir_q] = 1'b1;
      bus.nbr_id_o          = id_q;
    end
    if (state_q == ST_RSP) begin
      bus.rsp_valid_o = 1'b1;
      bus.rsp_dir_o   = dir_q;
      bus.rsp_id_o    = rsp_id_q;
      bus.rsp_error_o = err_q;
    end
  end

  assign busy_o = (state_q != ST_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_fractal_sync_nbr_ctrl.sv
// Directed bench for the neighbor sync sequencer: basic sync, back-to-back
// FIFO traffic, timeout and wake-at-limit, id mismatch, response back-pressure
// and reset during WAIT. Expected values are hand-derived cycle by cycle.
module tb_fractal_sync_nbr_ctrl;

  localparam int unsigned N_DIR      = 4;
  localparam int unsigned ID_W       = 2;
  localparam int unsigned FIFO_DEPTH = 2;
  localparam int unsigned TIMEOUT    = 8;

  logic clk_i  = 1'b0;
  logic rst_ni = 1'b0;
  logic busy_o;

  int n_cmp = 0;
  int n_mis = 0;

  fractal_sync_nbr_ctrl_if #(.N_DIR(N_DIR), .ID_W(ID_W)) bus ();

  fractal_sync_nbr_ctrl #(
    .N_DIR      (N_DIR),
    .ID_W       (ID_W),
    .FIFO_DEPTH (FIFO_DEPTH),
    .TIMEOUT    (TIMEOUT)
  ) dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .bus    (bus.slave),
    .busy_o (busy_o)
  );

  always #5 clk_i = ~clk_i;

  // Response fields packed as {valid, dir[1:0], id[1:0], error}.
  function automatic logic [5:0] rsp_now();
    return {bus.rsp_valid_o, bus.rsp_dir_o, bus.rsp_id_o, bus.rsp_error_o};
  endfunction

  function automatic logic [5:0] nbr_now();
    return {bus.nbr_sync_o, bus.nbr_id_o};
  endfunction

  // Advance to 1 time unit after the next rising edge.
  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_inputs();
    bus.req_valid_i = 1'b0;
    bus.req_dir_i   = '0;
    bus.req_id_i    = '0;
    bus.rsp_ready_i = 1'b0;
    bus.nbr_wake_i  = '0;
    bus.nbr_id_i    = '0;
  endtask

  task automatic push(input logic [1:0] d, input logic [1:0] id);
    bus.req_valid_i = 1'b1;
    bus.req_dir_i   = d;
    bus.req_id_i    = id;
    cyc();
    bus.req_valid_i = 1'b0;
  endtask

  // One-cycle wake from node d carrying id.
  task automatic wake(input int d, input logic [1:0] id);
    bus.nbr_wake_i              = '0;
    bus.nbr_wake_i[d]           = 1'b1;
    bus.nbr_id_i[d*ID_W +: ID_W] = id;
    cyc();
    bus.nbr_wake_i = '0;
  endtask

  task automatic ack();
    bus.rsp_ready_i = 1'b1;
    cyc();
    bus.rsp_ready_i = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_ni = 1'b0;
    repeat (2) cyc();
    n_cmp++; if (bus.req_ready_o !== 1'b1) begin n_mis++; $display("FAIL reset_ready: got %b want 1", bus.req_ready_o); end
    n_cmp++; if (rsp_now() !== 6'b0) begin n_mis++; $display("FAIL reset_rsp: got %b want 000000", rsp_now()); end
    n_cmp++; if (nbr_now() !== 6'b0) begin n_mis++; $display("FAIL reset_nbr: got %b want 000000", nbr_now()); end
    n_cmp++; if (busy_o !== 1'b0) begin n_mis++; $display("FAIL reset_busy: got %b want 0", busy_o); end
    @(negedge clk_i);
    rst_ni = 1'b1;
    cyc();
  endtask

  task automatic test_basic();
    push(2'd1, 2'd2);                       // accepted into FIFO
    n_cmp++; if (busy_o !== 1'b1) begin n_mis++; $display("FAIL basic_busy: got %b want 1", busy_o); end
    cyc();                                  // ISSUE
    n_cmp++; if (nbr_now() !== {4'b0010, 2'd2}) begin n_mis++; $display("FAIL basic_sync: got %b want 001010", nbr_now()); end
    cyc();                                  // WAIT cycle 1
    n_cmp++; if (bus.nbr_sync_o !== 4'b0000) begin n_mis++; $display("FAIL basic_sync_1cyc: got %b want 0000", bus.nbr_sync_o); end
    cyc();                                  // WAIT cycle 2
    wake(1, 2'd2);
    n_cmp++; if (rsp_now() !== {1'b1, 2'd1, 2'd2, 1'b0}) begin n_mis++; $display("FAIL basic_rsp: got %b want 101100", rsp_now()); end
    ack();
    n_cmp++; if ({bus.rsp_valid_o, busy_o} !== 2'b00) begin n_mis++; $display("FAIL basic_done: got %b want 00", {bus.rsp_valid_o, busy_o}); end
  endtask

  task automatic test_back_to_back();
    bus.req_valid_i = 1'b1; bus.req_dir_i = 2'd0; bus.req_id_i = 2'd0;
    cyc();                                  // push A
    bus.req_dir_i = 2'd2; bus.req_id_i = 2'd1;
    n_cmp++; if (bus.req_ready_o !== 1'b1) begin n_mis++; $display("FAIL b2b_ready_b: got %b want 1", bus.req_ready_o); end
    cyc();                                  // push B, pop A -> ISSUE A
    n_cmp++; if (nbr_now() !== {4'b0001, 2'd0}) begin n_mis++; $display("FAIL b2b_sync_a: got %b want 000100", nbr_now()); end
    bus.req_dir_i = 2'd3; bus.req_id_i = 2'd3;
    n_cmp++; if (bus.req_ready_o !== 1'b1) begin n_mis++; $display("FAIL b2b_ready_c: got %b want 1", bus.req_ready_o); end
    cyc();                                  // push C -> full, WAIT A
    bus.req_valid_i = 1'b0;
    n_cmp++; if (bus.req_ready_o !== 1'b0) begin n_mis++; $display("FAIL b2b_full: got %b want 0", bus.req_ready_o); end
    wake(0, 2'd0);
    n_cmp++; if (rsp_now() !== {1'b1, 2'd0, 2'd0, 1'b0}) begin n_mis++; $display("FAIL b2b_rsp_a: got %b want 100000", rsp_now()); end
    n_cmp++; if (bus.nbr_sync_o !== 4'b0000) begin n_mis++; $display("FAIL b2b_one_outstanding: got %b want 0000", bus.nbr_sync_o); end
    ack();                                  // IDLE
    cyc();                                  // ISSUE B
    n_cmp++; if (nbr_now() !== {4'b0100, 2'd1}) begin n_mis++; $display("FAIL b2b_sync_b: got %b want 010001", nbr_now()); end
    n_cmp++; if (bus.req_ready_o !== 1'b1) begin n_mis++; $display("FAIL b2b_ready_after_pop: got %b want 1", bus.req_ready_o); end
    cyc();                                  // WAIT B
    wake(2, 2'd1);
    n_cmp++; if (rsp_now() !== {1'b1, 2'd2, 2'd1, 1'b0}) begin n_mis++; $display("FAIL b2b_rsp_b: got %b want 110010", rsp_now()); end
    ack();
    cyc();                                  // ISSUE C
    n_cmp++; if (nbr_now() !== {4'b1000, 2'd3}) begin n_mis++; $display("FAIL b2b_sync_c: got %b want 100011", nbr_now()); end
    cyc();
    wake(3, 2'd3);
    n_cmp++; if (rsp_now() !== {1'b1, 2'd3, 2'd3, 1'b0}) begin n_mis++; $display("FAIL b2b_rsp_c: got %b want 111110", rsp_now()); end
    ack();
    n_cmp++; if (busy_o !== 1'b0) begin n_mis++; $display("FAIL b2b_idle: got %b want 0", busy_o); end
  endtask

  task automatic test_timeout();
    logic early;
    early = 1'b0;
    push(2'd2, 2'd3);
    cyc();                                  // ISSUE
    n_cmp++; if (nbr_now() !== {4'b0100, 2'd3}) begin n_mis++; $display("FAIL to_sync: got %b want 010011", nbr_now()); end
    for (int k = 0; k < 8; k++) begin
      cyc();                                // still in WAIT cycles 1..8
      if (bus.rsp_valid_o !== 1'b0) early = 1'b1;
    end
    n_cmp++; if (early !== 1'b0) begin n_mis++; $display("FAIL to_early: got %b want 0", early); end
    cyc();                                  // RSP after 8 WAIT cycles
    n_cmp++; if (rsp_now() !== {1'b1, 2'd2, 2'd3, 1'b1}) begin n_mis++; $display("FAIL to_rsp: got %b want 110111", rsp_now()); end
    ack();
    wake(2, 2'd3);                          // late wake must be ignored
    early = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if ({bus.rsp_valid_o, busy_o, |bus.nbr_sync_o} !== 3'b000) early = 1'b1;
      cyc();
    end
    n_cmp++; if (early !== 1'b0) begin n_mis++; $display("FAIL to_late_wake: got %b want 0", early); end
  endtask

  task automatic test_wake_at_limit();
    push(2'd1, 2'd0);
    cyc();                                  // ISSUE
    repeat (8) cyc();                       // now in WAIT cycle 8 (limit)
    n_cmp++; if (bus.rsp_valid_o !== 1'b0) begin n_mis++; $display("FAIL lim_pre: got %b want 0", bus.rsp_valid_o); end
    wake(1, 2'd0);
    n_cmp++; if (rsp_now() !== {1'b1, 2'd1, 2'd0, 1'b0}) begin n_mis++; $display("FAIL lim_wake_wins: got %b want 101000", rsp_now()); end
    ack();
  endtask

  task automatic test_mismatch();
    push(2'd3, 2'd3);
    cyc();                                  // ISSUE
    cyc();                                  // WAIT
    wake(0, 2'd3);                          // wrong direction
    n_cmp++; if (bus.rsp_valid_o !== 1'b0) begin n_mis++; $display("FAIL mm_wrong_dir: got %b want 0", bus.rsp_valid_o); end
    wake(3, 2'd1);
    n_cmp++; if (rsp_now() !== {1'b1, 2'd3, 2'd1, 1'b1}) begin n_mis++; $display("FAIL mm_rsp: got %b want 111011", rsp_now()); end
    ack();
  endtask

  task automatic test_rsp_hold();
    bus.req_valid_i = 1'b1; bus.req_dir_i = 2'd0; bus.req_id_i = 2'd1;
    cyc();
    bus.req_dir_i = 2'd1; bus.req_id_i = 2'd2;
    cyc();                                  // ISSUE A, B queued
    bus.req_valid_i = 1'b0;
    cyc();                                  // WAIT A
    wake(0, 2'd1);
    for (int k = 0; k < 5; k++) begin
      n_cmp++; if ({rsp_now(), bus.nbr_sync_o} !== {1'b1, 2'd0, 2'd1, 1'b0, 4'b0000}) begin
        n_mis++; $display("FAIL hold_stable[%0d]: got %b want 1000100000", k, {rsp_now(), bus.nbr_sync_o});
      end
      cyc();
    end
    ack();                                  // back to IDLE
    n_cmp++; if ({bus.rsp_valid_o, bus.nbr_sync_o} !== 5'b0) begin n_mis++; $display("FAIL hold_idle: got %b want 00000", {bus.rsp_valid_o, bus.nbr_sync_o}); end
    cyc();                                  // ISSUE B
    n_cmp++; if (nbr_now() !== {4'b0010, 2'd2}) begin n_mis++; $display("FAIL hold_next_sync: got %b want 001010", nbr_now()); end
    cyc();
    wake(1, 2'd2);
    n_cmp++; if (rsp_now() !== {1'b1, 2'd1, 2'd2, 1'b0}) begin n_mis++; $display("FAIL hold_rsp_b: got %b want 101100", rsp_now()); end
    ack();
  endtask

  task automatic test_reset_mid();
    logic seen;
    seen = 1'b0;
    bus.req_valid_i = 1'b1; bus.req_dir_i = 2'd1; bus.req_id_i = 2'd1;
    cyc();
    bus.req_dir_i = 2'd2; bus.req_id_i = 2'd0;
    cyc();                                  // ISSUE first, second queued
    bus.req_valid_i = 1'b0;
    cyc();                                  // WAIT
    #2;
    rst_ni = 1'b0;
    #1;
    n_cmp++; if ({bus.req_ready_o, busy_o} !== 2'b10) begin n_mis++; $display("FAIL rstmid_ready_busy: got %b want 10", {bus.req_ready_o, busy_o}); end
    n_cmp++; if ({rsp_now(), nbr_now()} !== 12'b0) begin n_mis++; $display("FAIL rstmid_outputs: got %b want 0", {rsp_now(), nbr_now()}); end
    repeat (2) cyc();
    @(negedge clk_i);
    rst_ni = 1'b1;
    wake(1, 2'd1);                          // stale wake for aborted sync
    for (int k = 0; k < 10; k++) begin
      if ({bus.rsp_valid_o, busy_o, |bus.nbr_sync_o} !== 3'b000) seen = 1'b1;
      cyc();
    end
    n_cmp++; if (seen !== 1'b0) begin n_mis++; $display("FAIL rstmid_quiet: got %b want 0", seen); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_timeout();
    test_wake_at_limit();
    test_mismatch();
    test_rsp_hold();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
